// File: rtl/wb_pkg.sv
// Shared encodings for the writeback-data unit and its load extender:
// writeback source selects, load sizes and FSM state constants.
package wb_pkg;

  localparam int WB_SEL_ALU    = 0;
  localparam int WB_SEL_MEM    = 1;
  localparam int WB_SEL_MEMEXT = 2;
  localparam int WB_SEL_CONST  = 3;

  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_WORD = 2'd2;

  typedef logic [1:0] wb_state_t;

  localparam wb_state_t S_IDLE     = 2'd0;
  localparam wb_state_t S_WAIT_MEM = 2'd1;
  localparam wb_state_t S_WRITE    = 2'd2;
  localparam wb_state_t S_ERROR    = 2'd3;

endpackage

// File: rtl/wb_data_unit_load_extender.sv
// Combinational sub-word extractor: picks a byte or halfword out of a memory
// word by byte offset and sign/zero-extends it; full words pass through.
module load_extender
  import wb_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [OFF_W-1:0]  off_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Halfword alignment drops the low offset bit.
  assign byte_s = word_i[{off_i, 3'b000} +: 8];
  assign half_s = word_i[{off_i[OFF_W-1:1], 4'b0000} +: 16];

  always_comb begin
    data_o = word_i;
    case (size_i)
      LD_BYTE: data_o = {{(DATA_W - 8){byte_s[7] & ~unsigned_i}}, byte_s};
      LD_HALF: data_o = {{(DATA_W - 16){half_s[15] & ~unsigned_i}}, half_s};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_data_unit.sv
// Registered writeback-data unit: selects the writeback source, waits for
// memory with a timeout and issues a one-cycle register-file write plus done.
module wb_data_unit
  import wb_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int SEL_W     = 4,
  parameter  int CONST_VAL = 227,
  parameter  int TIMEOUT   = 15,
  localparam int OFF_W     = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_req,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic [4:0]        wb_dest,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [OFF_W-1:0]  byte_off,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_ext_in,
  input  logic              mem_ready,
  output logic              busy,
  output logic              reg_wr,
  output logic [4:0]        reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              wb_done,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] CONST_WORD  = DATA_W'(CONST_VAL);
  localparam logic [SEL_W-1:0]  SEL_ALU     = SEL_W'(WB_SEL_ALU);
  localparam logic [SEL_W-1:0]  SEL_MEM     = SEL_W'(WB_SEL_MEM);
  localparam logic [SEL_W-1:0]  SEL_MEMEXT  = SEL_W'(WB_SEL_MEMEXT);
  localparam logic [SEL_W-1:0]  SEL_CONST   = SEL_W'(WB_SEL_CONST);

  wb_state_t         state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [4:0]        dest_q, dest_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              wr_q, wr_d;
  logic [4:0]        addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] ext_s;

  load_extender #(.DATA_W(DATA_W)) u_ext (
    .word_i     (mem_ext_in),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .off_i      (off_q),
    .data_o     (ext_s)
  );

  // Output strobes are computed from the transition so they line up with WRITE/ERROR.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dest_d  = dest_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_req) begin
          sel_d  = wb_sel;
          dest_d = wb_dest;
          size_d = ld_size;
          uns_d  = ld_unsigned;
          off_d  = byte_off;
          if ((wb_sel == SEL_ALU) || (wb_sel == SEL_CONST)) begin
            state_d = S_WRITE;
            addr_d  = wb_dest;
            data_d  = (wb_sel == SEL_ALU) ? alu_in : CONST_WORD;
            wr_d    = (wb_dest != 5'd0);
            done_d  = 1'b1;
          end else if ((wb_sel == SEL_MEM) || (wb_sel == SEL_MEMEXT)) begin
            state_d = S_WAIT_MEM;
            cnt_d   = '0;
          end else begin
            state_d = S_ERROR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_MEM: begin
        if (mem_ready) begin
          state_d = S_WRITE;
          addr_d  = dest_q;
          data_d  = (sel_q == SEL_MEMEXT) ? ext_s : mem_in;
          wr_d    = (dest_q != 5'd0);
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERROR;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, latched request controls and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      dest_q  <= 5'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 5'd0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dest_q  <= dest_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy        = busy_q;
  assign reg_wr      = wr_q;
  assign reg_wr_addr = addr_q;
  assign reg_wr_data = data_q;
  assign wb_done     = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_wb_data_unit.sv
// Randomized self-checking bench for wb_data_unit against a transaction-level
// reference model of the writeback rules.
module tb_wb_data_unit;

  localparam int DATA_W  = 32;
  localparam int SEL_W   = 4;
  localparam int TIMEOUT = 15;
  localparam int OFF_W   = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wb_req = 1'b0;
  logic [SEL_W-1:0]  wb_sel = '0;
  logic [4:0]        wb_dest = '0;
  logic [1:0]        ld_size = '0;
  logic              ld_unsigned = 1'b0;
  logic [OFF_W-1:0]  byte_off = '0;
  logic [DATA_W-1:0] alu_in = '0;
  logic [DATA_W-1:0] mem_in = '0;
  logic [DATA_W-1:0] mem_ext_in = '0;
  logic              mem_ready = 1'b0;
  logic              busy, reg_wr, wb_done, err;
  logic [4:0]        reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  wb_data_unit #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CONST_VAL(227), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .wb_req(wb_req), .wb_sel(wb_sel), .wb_dest(wb_dest),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned), .byte_off(byte_off),
    .alu_in(alu_in), .mem_in(mem_in), .mem_ext_in(mem_ext_in), .mem_ready(mem_ready),
    .busy(busy), .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .wb_done(wb_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference extraction: arithmetic on the field value, not bit slicing.
  function automatic logic [31:0] ext_model(input logic [31:0] word, input int size,
                                            input bit uns, input int off);
    longint unsigned w, f;
    int nbits, sh;
    w = word;
    if (size == 0) begin nbits = 8;  sh = 8 * off; end
    else if (size == 1) begin nbits = 16; sh = 16 * (off / 2); end
    else return word;
    f = (w >> sh) % (64'd1 << nbits);
    if (!uns && f >= (64'd1 << (nbits - 1))) f = f + (64'd1 << 32) - (64'd1 << nbits);
    return f[31:0];
  endfunction

  // One transaction: d = edge index (1-based after the request edge) where mem_ready is first seen.
  task automatic txn(input int sel, input int dest, input int size, input bit uns, input int off,
                     input int d, input logic [31:0] a, input logic [31:0] m, input logic [31:0] x,
                     input bit noise);
    int r; bit is_mem, is_err, exp_wr; logic [31:0] exp_data;
    is_mem = (sel == 1) || (sel == 2);
    is_err = (sel > 3) || (is_mem && d > TIMEOUT);
    r = is_mem ? ((d > TIMEOUT) ? TIMEOUT : d) : 0;
    exp_wr = !is_err && (dest != 0);
    case (sel)
      0: exp_data = a;
      1: exp_data = m;
      2: exp_data = ext_model(x, size, uns, off);
      default: exp_data = 32'd227;
    endcase
    wb_sel = SEL_W'(sel); wb_dest = 5'(dest); ld_size = 2'(size); ld_unsigned = uns;
    byte_off = OFF_W'(off); alu_in = a; mem_in = m; mem_ext_in = x;
    mem_ready = 1'b0; wb_req = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= r + 1; c++) begin
      if (c < r)
        check_eq("wait_flags", {busy, reg_wr, wb_done, err}, 4'b1000);
      else if (c == r) begin
        check_eq("resp_flags", {busy, reg_wr, wb_done, err}, {1'b1, exp_wr, 1'b1, is_err});
        if (exp_wr) begin
          check_eq("wr_addr", reg_wr_addr, 64'(dest));
          check_eq("wr_data", reg_wr_data, 64'(exp_data));
        end
      end else
        check_eq("idle_flags", {busy, reg_wr, wb_done, err}, 4'b0000);
      if (c == r + 1) break;
      wb_req = noise ? 1'($urandom) : 1'b0;
      if (noise) begin
        wb_sel = SEL_W'($urandom); wb_dest = 5'($urandom);
        ld_size = 2'($urandom); ld_unsigned = 1'($urandom); byte_off = OFF_W'($urandom);
      end
      mem_ready = is_mem ? (c + 1 >= d) : (noise ? 1'($urandom) : 1'b0);
      @(posedge clk); #1;
    end
    wb_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    #3;
    check_eq("reset_outs", {busy, reg_wr, wb_done, err, reg_wr_addr, reg_wr_data}, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    txn(0, 9, 0, 0, 0, 1, 32'h1234_5678, 32'h0, 32'h0, 0);
    txn(2, 4, 0, 0, 3, 2, 32'h0, 32'h0, 32'h80FF_0000, 0);
    txn(2, 4, 0, 1, 3, 2, 32'h0, 32'h0, 32'h80FF_0000, 0);
    txn(2, 5, 1, 1, 2, 1, 32'h0, 32'h0, 32'hBEEF_1234, 0);
    txn(2, 5, 1, 0, 0, 3, 32'h0, 32'h0, 32'hBEEF_1234, 0);
    txn(2, 6, 1, 0, 3, 2, 32'h0, 32'h0, 32'hBEEF_1234, 0);
    txn(1, 7, 0, 0, 0, TIMEOUT + 5, 32'h0, 32'hDEAD_BEEF, 32'h0, 0);
    txn(1, 7, 0, 0, 0, TIMEOUT, 32'h0, 32'hDEAD_BEEF, 32'h0, 0);
    txn(3, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0);
    txn(3, 31, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0);
    txn(7, 3, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0);

    // Reset while waiting for memory; a late mem_ready must not write
    wb_sel = SEL_W'(1); wb_dest = 5'd12; mem_in = 32'hCAFE_F00D; wb_req = 1'b1;
    @(posedge clk); #1; wb_req = 1'b0;
    @(posedge clk); #1;
    check_eq("busy_wait", busy, 1'b1);
    reset_n = 1'b0; #1;
    check_eq("async_rst", {busy, reg_wr, wb_done, err, reg_wr_addr, reg_wr_data}, 64'd0);
    @(negedge clk); reset_n = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("late_ready", {busy, reg_wr, wb_done, err}, 4'b0000);
    end
    mem_ready = 1'b0;

    // Randomized transactions with busy-time request noise
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 15);
      txn(sel, $urandom_range(0, 31), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
          $urandom_range(1, TIMEOUT + 3), $urandom, $urandom, $urandom, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
